// File: rtl/data_mem_arbiter.sv
// Shares one data memory between the pipeline MEM stage and a loader/DMA port; the pipeline has priority, and the loader wins after D_WAIT_MAX back-to-back pipeline grants.
// Each access takes one cycle, and done/rdata are registered on the following edge; stall holds the pipeline until its done pulse.
module data_mem_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 64,
  parameter int D_WAIT_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_done,
  output logic              stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  localparam int CW = (D_WAIT_MAX < 1) ? 1 : $clog2(D_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(D_WAIT_MAX);

  typedef enum logic [1:0] {IDLE, ACC_P, ACC_D} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     wait_cnt;
  logic              wait_sat;
  logic              grant_p, grant_d;
  logic              acc, in_range;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  assign wait_sat = (wait_cnt >= WAIT_MAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // The loader only wins a tie once the pipeline has used up its run of grants.
  always_comb begin
    state_nxt = IDLE;
    grant_p   = 1'b0;
    grant_d   = 1'b0;
    if (state == IDLE) begin
      if (p_req && (!d_req || !wait_sat)) begin
        grant_p   = 1'b1;
        state_nxt = ACC_P;
      end else if (d_req) begin
        grant_d   = 1'b1;
        state_nxt = ACC_D;
      end
    end
  end

  always_comb begin
    acc      = (state != IDLE);
    in_range = (32'(acc_addr) < 32'(DEPTH));
    mem_WE   = acc && acc_we && in_range;
    stall    = p_req && !p_done;
  end

  assign mem_A  = acc_addr;
  assign mem_WD = acc_wdata;

  // Request fields are captured at grant so later changes cannot disturb the access.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      wait_cnt  <= '0;
    end else if (grant_p) begin
      acc_we    <= p_we;
      acc_addr  <= p_addr;
      acc_wdata <= p_wdata;
      wait_cnt  <= d_req ? (wait_sat ? wait_cnt : wait_cnt + 1'b1) : '0;
    end else if (grant_d) begin
      acc_we    <= d_we;
      acc_addr  <= d_addr;
      acc_wdata <= d_wdata;
      wait_cnt  <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_done   <= 1'b0;
      d_done   <= 1'b0;
      addr_err <= 1'b0;
      p_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      p_done   <= (state == ACC_P);
      d_done   <= (state == ACC_D);
      addr_err <= acc && !in_range;
      if (state == ACC_P && !acc_we) p_rdata <= in_range ? mem_RD : '0;
      if (state == ACC_D && !acc_we) d_rdata <= in_range ? mem_RD : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a per-cycle vector table plus contention and reset sequences.
module tb_data_mem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        CLK, RST_N;
  logic        p_req, p_we, d_req, d_we;
  logic [15:0] p_addr, p_wdata, d_addr, d_wdata;
  logic [15:0] p_rdata, d_rdata, mem_A, mem_WD, mem_RD;
  logic        p_done, d_done, stall, addr_err, mem_WE;

  logic [15:0] tmem [256];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic p_req, p_we; logic [15:0] p_addr, p_wdata;
    logic d_req, d_we; logic [15:0] d_addr, d_wdata;
    logic e_pd, e_dd, e_err, e_stall, e_we;
    logic [15:0] e_a, e_wd, e_prd, e_drd;
  } vec_t;

  vec_t vt [14];

  data_mem_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_done(p_done), .stall(stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .addr_err(addr_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory is 256 words deep so stray writes above DEPTH would be visible.
  assign mem_RD = tmem[mem_A[7:0]];
  always @(posedge CLK) if (mem_WE) tmem[mem_A[7:0]] <= mem_WD;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Both requesters read fixed words; bit k of each mask is the value in cycle k.
  task automatic run_seq(input string nm, input int n, input logic [15:0] preq_m, input logic [15:0] dreq_m,
                         input logic [15:0] pd_m, input logic [15:0] dd_m, input logic [15:0] st_m);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      p_req = preq_m[k]; p_we = 1'b0; p_addr = 16'h0001; p_wdata = 16'h0;
      d_req = dreq_m[k]; d_we = 1'b0; d_addr = 16'h0002; d_wdata = 16'h0;
      @(negedge CLK);
      chk1($sformatf("%s k%0d p_done", nm, k), p_done, pd_m[k]);
      chk1($sformatf("%s k%0d d_done", nm, k), d_done, dd_m[k]);
      chk1($sformatf("%s k%0d stall", nm, k), stall, st_m[k]);
      chk1($sformatf("%s k%0d both_done", nm, k), p_done & d_done, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tmem[i] = 16'hA000 + 16'(i);
    RST_N = 1'b0;
    p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

    //           p_req p_we p_addr    p_wdata    d_req d_we d_addr    d_wdata    pd dd er st we  mem_A     mem_WD     p_rdata    d_rdata
    vt[0]  = '{H, H, 16'h0005, 16'h1234, L, L, 16'h0000, 16'h0000, L, L, L, H, L, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[1]  = '{H, H, 16'h0009, 16'hFFFF, L, L, 16'h0000, 16'h0000, L, L, L, H, H, 16'h0005, 16'h1234, 16'h0000, 16'h0000};
    vt[2]  = '{H, L, 16'h0005, 16'h0000, L, L, 16'h0000, 16'h0000, H, L, L, L, L, 16'h0005, 16'h1234, 16'h0000, 16'h0000};
    vt[3]  = '{H, L, 16'h0005, 16'h0000, L, L, 16'h0000, 16'h0000, L, L, L, H, L, 16'h0005, 16'h0000, 16'h0000, 16'h0000};
    vt[4]  = '{L, L, 16'h0000, 16'h0000, L, L, 16'h0000, 16'h0000, H, L, L, L, L, 16'h0005, 16'h0000, 16'h1234, 16'h0000};
    vt[5]  = '{L, L, 16'h0000, 16'h0000, H, L, 16'h0007, 16'h0000, L, L, L, L, L, 16'h0005, 16'h0000, 16'h1234, 16'h0000};
    vt[6]  = '{L, L, 16'h0000, 16'h0000, H, L, 16'h0007, 16'h0000, L, L, L, L, L, 16'h0007, 16'h0000, 16'h1234, 16'h0000};
    vt[7]  = '{L, L, 16'h0000, 16'h0000, H, H, 16'h0040, 16'hBEEF, L, H, L, L, L, 16'h0007, 16'h0000, 16'h1234, 16'hA007};
    vt[8]  = '{L, L, 16'h0000, 16'h0000, H, H, 16'h0040, 16'hBEEF, L, L, L, L, L, 16'h0040, 16'hBEEF, 16'h1234, 16'hA007};
    vt[9]  = '{L, L, 16'h0000, 16'h0000, H, L, 16'h0064, 16'h0000, L, H, H, L, L, 16'h0040, 16'hBEEF, 16'h1234, 16'hA007};
    vt[10] = '{L, L, 16'h0000, 16'h0000, H, L, 16'h0064, 16'h0000, L, L, L, L, L, 16'h0064, 16'h0000, 16'h1234, 16'hA007};
    vt[11] = '{H, L, 16'h0040, 16'h0000, L, L, 16'h0000, 16'h0000, L, H, H, H, L, 16'h0064, 16'h0000, 16'h1234, 16'h0000};
    vt[12] = '{H, L, 16'h0040, 16'h0000, L, L, 16'h0000, 16'h0000, L, L, L, H, L, 16'h0040, 16'h0000, 16'h1234, 16'h0000};
    vt[13] = '{L, L, 16'h0000, 16'h0000, L, L, 16'h0000, 16'h0000, H, L, H, L, L, 16'h0040, 16'h0000, 16'h0000, 16'h0000};

    #3;
    chk1("rst p_done", p_done, 1'b0);
    chk1("rst d_done", d_done, 1'b0);
    chk1("rst addr_err", addr_err, 1'b0);
    chk1("rst mem_WE", mem_WE, 1'b0);
    chk16("rst mem_A", mem_A, 16'h0);
    chk16("rst mem_WD", mem_WD, 16'h0);
    chk16("rst p_rdata", p_rdata, 16'h0);
    chk16("rst d_rdata", d_rdata, 16'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(posedge CLK); #1;
      p_req = vt[i].p_req; p_we = vt[i].p_we; p_addr = vt[i].p_addr; p_wdata = vt[i].p_wdata;
      d_req = vt[i].d_req; d_we = vt[i].d_we; d_addr = vt[i].d_addr; d_wdata = vt[i].d_wdata;
      @(negedge CLK);
      chk1($sformatf("c%0d p_done", i), p_done, vt[i].e_pd);
      chk1($sformatf("c%0d d_done", i), d_done, vt[i].e_dd);
      chk1($sformatf("c%0d addr_err", i), addr_err, vt[i].e_err);
      chk1($sformatf("c%0d stall", i), stall, vt[i].e_stall);
      chk1($sformatf("c%0d mem_WE", i), mem_WE, vt[i].e_we);
      chk16($sformatf("c%0d mem_A", i), mem_A, vt[i].e_a);
      chk16($sformatf("c%0d mem_WD", i), mem_WD, vt[i].e_wd);
      chk16($sformatf("c%0d p_rdata", i), p_rdata, vt[i].e_prd);
      chk16($sformatf("c%0d d_rdata", i), d_rdata, vt[i].e_drd);
    end
    chk16("mem[5] written", tmem[5], 16'h1234);
    chk16("mem[9] untouched", tmem[9], 16'hA009);
    chk16("mem[64] untouched", tmem[64], 16'hA040);
    chk16("mem[100] untouched", tmem[100], 16'hA064);

    // Held contention: P,P,P,P,D then P once the loader drops.
    run_seq("contend", 13, 16'h0FFF, 16'h03FF, 16'h1154, 16'h0400, 16'h0EAB);
    chk16("contend p_rdata", p_rdata, 16'hA001);
    chk16("contend d_rdata", d_rdata, 16'hA002);
    // Saturate the wait count, go idle, then raise both: loader first, pipeline stalls 4 cycles.
    run_seq("dfirst", 15, 16'h3CFF, 16'h0CFF, 16'h4154, 16'h1000, 16'h3CAB);

    @(posedge CLK); #1;
    p_req = 1'b1; p_we = 1'b1; p_addr = 16'h0003; p_wdata = 16'h5555;
    d_req = 1'b0;
    @(posedge CLK); #1;
    chk1("racc mem_WE", mem_WE, 1'b1);
    chk16("racc mem_A", mem_A, 16'h0003);
    RST_N = 1'b0; p_req = 1'b0; p_we = 1'b0;
    #1;
    chk1("rmid mem_WE", mem_WE, 1'b0);
    chk16("rmid mem_A", mem_A, 16'h0);
    chk16("rmid mem_WD", mem_WD, 16'h0);
    chk16("rmid p_rdata", p_rdata, 16'h0);
    chk16("rmid d_rdata", d_rdata, 16'h0);
    chk1("rmid p_done", p_done, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1; p_req = 1'b1; p_addr = 16'h0003;
    @(posedge CLK); #1;
    chk1("rrel p_done", p_done, 1'b0);
    chk16("rrel first grant mem_A", mem_A, 16'h0003);
    chk1("rrel stall", stall, 1'b1);
    @(posedge CLK); #1;
    chk1("rrd p_done", p_done, 1'b1);
    chk16("rrd p_rdata", p_rdata, 16'hA003);
    p_req = 1'b0;
    @(posedge CLK); #1;
    chk1("rend p_done", p_done, 1'b0);
    chk16("mem[3] after abort", tmem[3], 16'hA003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
